piso_serializer: RTL and testbench

//  Parallel-in/serial-out stage that sits directly upstream of the 4-bit SIPO shift register.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_bit_counter.sv | 30 +++
 rtl/piso_serializer.sv | 140 ++++++++++++++
 tb/tb_piso_serializer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state type and reset constants for the PISO serializer
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } piso_state_t;

  localparam piso_state_t RST_STATE      = IDLE;
  localparam logic        RST_SOUT       = 1'b0;
  localparam logic        RST_SOUT_VALID = 1'b0;

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - clear/enable up-counter that saturates at MAX and flags it
module piso_bit_counter #(
  parameter int W   = 3,
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  // Holds at MAX instead of wrapping; the owner clears it when its state is (re)entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == MAX_V);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - LSB-first parallel-to-serial stage with gap; PISO_PARITY_EN adds an even-parity bit
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int BW   = $clog2(WIDTH + 1);
  localparam int GW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GMAX = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  piso_state_t      r_state;
  piso_state_t      w_next;
  logic [WIDTH-1:0] r_shift;
  logic             r_sout;
  logic             r_sout_valid;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_gap_done;
`ifdef PISO_PARITY_EN
  logic             r_parity;
`endif

  // Bit counter tracks which data bit is currently on sout (0 right after accept).
  piso_bit_counter #(.W(BW), .MAX(WIDTH - 1)) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept),
    .i_en    (r_state == SHIFT),
    .o_tc    (w_last_bit)
  );

  piso_bit_counter #(.W(GW), .MAX(GMAX)) u_gap_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state != GAP),
    .i_en    (r_state == GAP),
    .o_tc    (w_gap_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_bit) begin
`ifdef PISO_PARITY_EN
          w_next = PARITY;
`else
          w_next = (GAP_CYCLES > 0) ? GAP : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        w_next = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
`endif
      GAP: begin
        if (w_gap_done) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Bit 0 is launched on the accept edge; each SHIFT edge launches the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift      <= '0;
      r_sout       <= RST_SOUT;
      r_sout_valid <= RST_SOUT_VALID;
`ifdef PISO_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      if (w_accept) begin
        r_shift      <= in_data >> 1;
        r_sout       <= in_data[0];
        r_sout_valid <= 1'b1;
`ifdef PISO_PARITY_EN
        r_parity     <= ^in_data;
`endif
      end else if (r_state == SHIFT) begin
        if (!w_last_bit) begin
          r_shift      <= r_shift >> 1;
          r_sout       <= r_shift[0];
          r_sout_valid <= 1'b1;
        end
`ifdef PISO_PARITY_EN
        else begin
          r_sout       <= r_parity;
          r_sout_valid <= 1'b1;
        end
`endif
      end
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
`ifdef PISO_PARITY_EN
  assign frame_done = (r_state == PARITY);
`else
  assign frame_done = (r_state == SHIFT) && w_last_bit;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (GAP=1 and GAP=0 instances)
module tb_piso_serializer;

  localparam int W   = 4;
  localparam int GAP = 1;
`ifdef PISO_PARITY_EN
  localparam int FL  = W + 1;
`else
  localparam int FL  = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, sout, sout_valid, frame_done, busy;

  logic [W-1:0] g_in_data = '0;
  logic         g_in_valid = 1'b0;
  logic         g_in_ready, g_sout, g_sout_valid, g_frame_done, g_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_bits  = 0;
  int n_frames = 0;
  logic [W-1:0] sipo_q = '0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sout(sout), .sout_valid(sout_valid), .frame_done(frame_done), .busy(busy)
  );

  piso_serializer #(.WIDTH(W), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst), .in_data(g_in_data), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .sout(g_sout), .sout_valid(g_sout_valid), .frame_done(g_frame_done), .busy(g_busy)
  );

  // Downstream SIPO: shifts every clock, first bit ends up in q[0].
  always @(posedge clk) sipo_q <= {sout, sipo_q[W-1:1]};

  always @(negedge clk) if (!rst && sout_valid) n_bits++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [W-1:0] word, input int idx);
    if (idx < W) return word[idx];
    return ^word;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", in_ready, 1);
  endtask

  // Called at a negedge; returns at the negedge of the first idle cycle after the frame.
  task automatic send_frame(input logic [W-1:0] word, input bit hold_junk);
    wait_ready();
    in_data  = word;
    in_valid = 1'b1;
    n_frames++;
    for (int c = 1; c <= FL + GAP; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold_junk) in_data = {W{1'b1}};
        else in_valid = 1'b0;
      end
      check("in_ready_busy", in_ready, 0);
      check("busy", busy, 1);
      if (c <= FL) begin
        check("sout_valid", sout_valid, 1);
        check("sout", sout, exp_bit(word, c - 1));
        check("frame_done", frame_done, (c == FL));
      end else begin
        check("gap_valid", sout_valid, 0);
        check("gap_sout", sout, 0);
        check("gap_done", frame_done, 0);
      end
      if (c == W + 1) check("sipo_q", sipo_q, word);
      if (c == FL + GAP) in_valid = 1'b0;
    end
    @(negedge clk);
    check("in_ready_after", in_ready, 1);
    check("busy_after", busy, 0);
    check("idle_valid", sout_valid, 0);
  endtask

  initial begin
    #1;
    check("rst_sout", sout, 0);
    check("rst_valid", sout_valid, 0);
    check("rst_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    send_frame(4'b1011, 1'b0);
    send_frame(4'hA, 1'b0);
    send_frame(4'h5, 1'b0);
    send_frame(4'h6, 1'b1);

    // Reset mid-frame after two bits of 4'b0110.
    wait_ready();
    in_data  = 4'b0110;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_bit0", sout, 0);
    @(negedge clk);
    check("mid_bit1", sout, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sout", sout, 0);
    check("mid_rst_valid", sout_valid, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", sout_valid, 0);
    send_frame(4'h9, 1'b0);

    for (int i = 0; i < 10; i++) begin
      send_frame(W'($urandom), 1'($urandom));
    end

    check("bit_total", n_bits, n_frames * FL + 2);

    // GAP_CYCLES=0 instance: next accept one cycle after frame_done.
    begin
      logic [W-1:0] w1, w2;
      int n = 0;
      w1 = W'($urandom);
      w2 = W'($urandom);
      g_in_data  = w1;
      g_in_valid = 1'b1;
      @(negedge clk);
      check("g0_bit0", g_sout, w1[0]);
      while (!g_frame_done && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("g0_frame_done", g_frame_done, 1);
      check("g0_done_cycle", n, FL - 1);
      @(negedge clk);
      check("g0_ready", g_in_ready, 1);
      check("g0_idle_valid", g_sout_valid, 0);
      g_in_data = w2;
      @(negedge clk);
      g_in_valid = 1'b0;
      check("g0_next_valid", g_sout_valid, 1);
      check("g0_next_bit0", g_sout, w2[0]);
      check("g0_busy", g_busy, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
